// File: rtl/pixel_writer.sv
// Pixel stream to Avalon-MM framebuffer writer: queues (x, y, colour) words in a small FIFO,
// discards off-screen pixels and issues one 32-bit write per on-screen pixel, in order.
module pixel_writer #(
   parameter int unsigned H_RES      = 640,
   parameter int unsigned V_RES      = 480,
   parameter logic [31:0] FB_BASE    = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [63:0] pixel_data,
   input  logic        pixel_data_valid,
   output logic        pixel_fifo_full,
   output logic        pixel_fifo_empty,
   output logic        busy,
   output logic [31:0] avm_address,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   output logic        avm_write,
   input  logic        avm_waitrequest,
   output logic [31:0] pixels_written,
   output logic [15:0] pixels_clipped
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0]   LP_DEPTH  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [31:0]   LP_H_RES  = 32'(H_RES);
   localparam logic [31:0]   LP_V_RES  = 32'(V_RES);
   localparam logic [AW-1:0] LP_PTR_1  = AW'(1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CALC  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;

   logic [63:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic [1:0]  r_state;
   logic [15:0] r_x;
   logic [15:0] r_y;
   logic [31:0] r_col;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_write;
   logic [31:0] r_written;
   logic [15:0] r_clipped;

   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic        w_clip;
   logic [31:0] w_lin;
   logic [31:0] w_addr;
   logic [63:0] w_head;

   assign w_full  = (r_count == LP_DEPTH);
   assign w_empty = (r_count == '0);
   assign w_push  = pixel_data_valid && !w_full;
   assign w_head  = r_mem[r_rd_ptr];

   // Every state that finishes with the current pixel pulls the next one straight from the FIFO.
   always_comb begin
      w_pop = 1'b0;
      unique case (r_state)
         IDLE:    w_pop = !w_empty;
         CALC:    w_pop = w_clip && !w_empty;
         WRITE:   w_pop = !avm_waitrequest && !w_empty;
         default: w_pop = 1'b0;
      endcase
   end

   assign w_clip = ({16'd0, r_x} >= LP_H_RES) || ({16'd0, r_y} >= LP_V_RES);
   assign w_lin  = ({16'd0, r_y} * LP_H_RES) + {16'd0, r_x};
   assign w_addr = FB_BASE + {w_lin[29:0], 2'b00};

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= pixel_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + LP_PTR_1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + LP_PTR_1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_x       <= '0;
         r_y       <= '0;
         r_col     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_write   <= 1'b0;
         r_written <= '0;
         r_clipped <= '0;
      end else begin
         if (w_pop) begin
            r_x   <= w_head[63:48];
            r_y   <= w_head[47:32];
            r_col <= w_head[31:0];
         end
         unique case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_state <= CALC;
               end
            end
            CALC: begin
               if (w_clip) begin
                  r_clipped <= r_clipped + 16'd1;
                  r_state   <= w_empty ? IDLE : CALC;
               end else begin
                  r_addr  <= w_addr;
                  r_wdata <= r_col;
                  r_write <= 1'b1;
                  r_state <= WRITE;
               end
            end
            WRITE: begin
               if (!avm_waitrequest) begin
                  r_write   <= 1'b0;
                  r_written <= r_written + 32'd1;
                  r_state   <= w_empty ? IDLE : CALC;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign pixel_fifo_full  = w_full;
   assign pixel_fifo_empty = w_empty;
   assign busy             = !w_empty || (r_state != IDLE);
   assign avm_address      = r_addr;
   assign avm_writedata    = r_wdata;
   assign avm_byteenable   = 4'hF;
   assign avm_write        = r_write;
   assign pixels_written   = r_written;
   assign pixels_clipped   = r_clipped;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: reset, single write, clipping, backpressure, waitrequest
// hold, full-rate streaming and reset during a write.
module tb_pixel_writer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [63:0] pixel_data = '0;
   logic        pixel_data_valid = 1'b0;
   logic        pixel_fifo_full;
   logic        pixel_fifo_empty;
   logic        busy;
   logic [31:0] avm_address;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_write;
   logic        avm_waitrequest = 1'b0;
   logic [31:0] pixels_written;
   logic [15:0] pixels_clipped;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] q_addr[$];
   logic [31:0] q_data[$];
   int          q_cyc[$];

   pixel_writer #(
      .H_RES     (640),
      .V_RES     (480),
      .FB_BASE   (32'h0000_0000),
      .FIFO_DEPTH(8)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .pixel_data      (pixel_data),
      .pixel_data_valid(pixel_data_valid),
      .pixel_fifo_full (pixel_fifo_full),
      .pixel_fifo_empty(pixel_fifo_empty),
      .busy            (busy),
      .avm_address     (avm_address),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_write       (avm_write),
      .avm_waitrequest (avm_waitrequest),
      .pixels_written  (pixels_written),
      .pixels_clipped  (pixels_clipped)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Log each write that will complete on the coming rising edge.
   always @(negedge clock) begin
      if (avm_write && !avm_waitrequest) begin
         q_addr.push_back(avm_address);
         q_data.push_back(avm_writedata);
         q_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [31:0] c);
      bit ok;
      ok = 1'b0;
      pixel_data       = {x, y, c};
      pixel_data_valid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (!pixel_fifo_full) begin
            tick();
            ok = 1'b1;
            break;
         end
         tick();
      end
      pixel_data_valid = 1'b0;
      if (!ok) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic clear_log();
      q_addr.delete();
      q_data.delete();
      q_cyc.delete();
   endtask

   initial begin
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_write", avm_write, 0);
      chk("rst_addr", avm_address, 0);
      chk("rst_data", avm_writedata, 0);
      chk("rst_written", pixels_written, 0);
      chk("rst_clipped", {16'd0, pixels_clipped}, 0);
      chk("rst_full", pixel_fifo_full, 0);
      chk("rst_empty", pixel_fifo_empty, 1);
      chk("rst_busy", busy, 0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Single pixel and its latency.
      clear_log();
      push(16'd3, 16'd2, 32'hFF00FF00);
      chk("single_e0_empty", pixel_fifo_empty, 0);
      chk("single_e0_write", avm_write, 0);
      tick();
      chk("single_e1_empty", pixel_fifo_empty, 1);
      chk("single_e1_write", avm_write, 0);
      tick();
      chk("single_e2_write", avm_write, 1);
      chk("single_addr", avm_address, (2 * 640 + 3) * 4);
      chk("single_data", avm_writedata, 32'hFF00FF00);
      chk("single_be", {28'd0, avm_byteenable}, 32'hF);
      tick();
      chk("single_e3_write", avm_write, 0);
      chk("single_written", pixels_written, 1);
      chk("single_busy", busy, 0);
      chk("single_nwrites", q_addr.size(), 1);

      // Clipping: three off-screen pixels, then the bottom-right corner.
      clear_log();
      push(16'd640, 16'd0, 32'h11111111);
      push(16'd0, 16'd480, 32'h22222222);
      push(16'hFFFF, 16'd5, 32'h33333333);
      push(16'd639, 16'd479, 32'h44444444);
      wait_idle();
      chk("clip_count", {16'd0, pixels_clipped}, 3);
      chk("clip_nwrites", q_addr.size(), 1);
      if (q_addr.size() >= 1) begin
         chk("clip_addr", q_addr[0], 32'h0012_BFFC);
         chk("clip_data", q_data[0], 32'h44444444);
      end
      chk("clip_written", pixels_written, 2);

      // Backpressure: slave stalled, 9 pixels fit (8 queued + 1 in flight).
      clear_log();
      avm_waitrequest = 1'b1;
      for (int i = 0; i < 9; i++) push(16'(i), 16'd1, 32'hC0DE0000 + 32'(i));
      chk("bp_full", pixel_fifo_full, 1);
      chk("bp_write_held", avm_write, 1);
      pixel_data       = {16'd9, 16'd1, 32'hC0DE0009};
      pixel_data_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_still_full", pixel_fifo_full, 1);
      end
      chk("bp_no_writes", q_addr.size(), 0);
      avm_waitrequest = 1'b0;
      for (int i = 9; i < 12; i++) push(16'(i), 16'd1, 32'hC0DE0000 + 32'(i));
      wait_idle();
      chk("bp_nwrites", q_addr.size(), 12);
      for (int i = 0; i < 12 && i < q_addr.size(); i++) begin
         chk($sformatf("bp_addr%0d", i), q_addr[i], 32'((640 + i) * 4));
         chk($sformatf("bp_data%0d", i), q_data[i], 32'hC0DE0000 + 32'(i));
      end
      chk("bp_written", pixels_written, 14);

      // Waitrequest held for 5 cycles mid-write.
      avm_waitrequest = 1'b1;
      push(16'd10, 16'd20, 32'hDEADBEEF);
      tick();
      tick();
      chk("wr_write", avm_write, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("wr_hold_write", avm_write, 1);
         chk("wr_hold_addr", avm_address, (20 * 640 + 10) * 4);
         chk("wr_hold_data", avm_writedata, 32'hDEADBEEF);
         chk("wr_hold_count", pixels_written, 14);
      end
      avm_waitrequest = 1'b0;
      tick();
      chk("wr_done_write", avm_write, 0);
      chk("wr_done_count", pixels_written, 15);

      // Full-rate stream of 100 pixels.
      clear_log();
      for (int i = 0; i < 100; i++) push(16'(i), 16'd3, 32'hA5000000 + 32'(i));
      wait_idle();
      chk("fr_nwrites", q_addr.size(), 100);
      for (int i = 0; i < 100 && i < q_addr.size(); i++) begin
         chk($sformatf("fr_addr%0d", i), q_addr[i], 32'((3 * 640 + i) * 4));
         if (i > 0) chk($sformatf("fr_gap%0d", i), 32'(q_cyc[i] - q_cyc[i-1]), 2);
      end
      chk("fr_written", pixels_written, 115);

      // Reset while a write is stalled with 4 pixels queued.
      avm_waitrequest = 1'b1;
      for (int i = 0; i < 5; i++) push(16'(i), 16'd7, 32'h77000000 + 32'(i));
      chk("mr_write_before", avm_write, 1);
      chk("mr_empty_before", pixel_fifo_empty, 0);
      #2 reset_n = 1'b0;
      #1;
      chk("mr_write", avm_write, 0);
      chk("mr_written", pixels_written, 0);
      chk("mr_clipped", {16'd0, pixels_clipped}, 0);
      chk("mr_empty", pixel_fifo_empty, 1);
      chk("mr_busy", busy, 0);
      tick();
      reset_n = 1'b1;
      avm_waitrequest = 1'b0;
      tick();
      clear_log();
      push(16'd5, 16'd5, 32'h12345678);
      wait_idle();
      chk("mr_post_nwrites", q_addr.size(), 1);
      if (q_addr.size() >= 1) begin
         chk("mr_post_addr", q_addr[0], (5 * 640 + 5) * 4);
         chk("mr_post_data", q_data[0], 32'h12345678);
      end
      chk("mr_post_written", pixels_written, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
